silife_max7219_rx: RTL and testbench
====================================

// Module: silife_max7219_rx
// PURPOSE
//  MAX7219-compatible serial receiver: the display end of the chained-MAX7219 link that
//  silife_max7219 drives. Samples CS/SCK/MOSI from an external master and decodes
//  cascaded 16-bit frames. Turns digit writes into grid row writes for grid_8x32, and
//  keeps shadow intensity/shutdown/test registers. This lets the design be loaded, or
//  looped back, over the same protocol it transmits.
// PARAMETERS
//  NUM_DEVICES  4   cascaded 8x8 devices emulated; rows = 8*NUM_DEVICES, must be <= 32
// PORTS
//  clk           in   1  system clock; single clock domain
//  rst_n         in   1  reset, asynchronous, active-low
//  i_cs          in   1  chip select from master, active-low, asynchronous to clk
//  i_sck         in   1  serial clock from master, asynchronous to clk
//  i_mosi        in   1  serial data from master, MSB first, asynchronous to clk
//  o_wr_en       out  1  one-cycle row write strobe
//  o_row_select  out  5  grid row written while o_wr_en is high
//  o_cells       out  8  row data D7..D0, passed unchanged to the grid
//  o_brightness  out  4  intensity register (addr 0xA, D3..D0)
//  o_shutdown    out  1  1 = shutdown mode (addr 0xC, equals ~D0)
//  o_test        out  1  display-test register (addr 0xF, D0)
//  o_busy        out  1  high while a latched frame is being decoded
//  o_frame_err   out  1  one-cycle pulse: frame discarded because of wrong bit count
// BEHAVIOUR
//  Reset values (rst_n low, async):
//   - o_wr_en=0, o_row_select=0, o_cells=0, o_brightness=0, o_shutdown=1, o_test=0,
//     o_busy=0, o_frame_err=0.
//   - Bit counter, shift register and frame buffer all clear; any pending decode is dropped.
//  Input sync:
//   - i_cs, i_sck and i_mosi each pass through 2 FFs; CS and SCK then get edge detection.
//   - Each SCK level must be held for >= 3 clk periods. Faster SCK is out of spec.
//  Shift phase (synced CS low):
//   - Each synced SCK rising edge shifts synced MOSI into the LSB of a 16*NUM_DEVICES-bit
//     shift register and increments the bit counter.
//   - The bit counter saturates at 16*NUM_DEVICES+1.
//   - SCK edges while CS is high are ignored.
//   - A CS falling edge clears the bit counter.
//  Latch (synced CS rising edge):
//   - Bit count == 16*NUM_DEVICES: copy the shift register into the frame buffer, go to
//     DECODE, assert o_busy on the next cycle.
//   - Any other count (short frame, long frame, or 0): pulse o_frame_err for 1 cycle;
//     registers are unchanged.
//   - A CS rise while already in DECODE with a valid count: the new frame replaces the
//     buffer, and decode restarts at slot 0.
//  Slot mapping:
//   - Slot d = frame_buffer[16*d +: 16]. Slot 0 holds the last 16 bits shifted in and is
//     device 0, the one nearest the master.
//   - Within a slot: addr = bits[11:8], data = bits[7:0]; bits[15:12] are ignored.
//  FSM: IDLE -> DECODE -> IDLE.
//   - DECODE handles one slot per cycle, d = 0..NUM_DEVICES-1.
//   - It returns to IDLE after slot NUM_DEVICES-1 and drops o_busy in that same cycle.
//   - Decode runs on the frame buffer, so the shift phase of the next frame may overlap it.
//  Per-slot action (outputs registered, one cycle after the slot is examined):
//   - addr 1..8: o_wr_en=1, o_row_select=8*d+addr-1, o_cells=data.
//   - addr 0xA: o_brightness <= data[3:0].
//   - addr 0xC: o_shutdown <= ~data[0].
//   - addr 0xF: o_test <= data[0].
//   - addr 0x0, 0x9, 0xB, 0xD, 0xE: no effect.
//   - When several slots write the same control register in one frame, the highest d wins.
//  Timing:
//   - Latency from the CS rising pin edge to the first o_wr_en is <= 5 clk: 2 sync stages,
//     1 edge detect, 1 latch, 1 output register.
//   - o_row_select and o_cells hold their last values when o_wr_en is low.
// STRUCTURE
//  - Shared defines header holds: SILIFE_MAX_REG_NOOP=0, DIGIT0=1..DIGIT7=8, DECODE=9,
//    INTENSITY=A, SCANLIMIT=B, SHUTDOWN=C, TEST=F.
//  - The transmitter silife_max7219 uses the same header.
//  - Sub-module silife_sync_edge: 2-FF synchronizer with rise/fall pulse outputs, asynchronous
//    active-low reset. Instantiated for CS and SCK; MOSI uses its synchronized output only.
//  - This module contains the shift register, bit counter, frame buffer, decode FSM and
//    output registers.
// TESTING
//  - Reset: rst_n low -> o_shutdown=1, o_brightness=0, o_test=0, o_busy=0, o_wr_en=0.
//    Release with no traffic -> outputs stay at reset values.
//  - Full frame, NUM_DEVICES=4, words 0x0181,0x0242,0x0324,0x0818 sent in that order, last
//    word to device 0, SCK period 8 clk -> four o_wr_en pulses in consecutive cycles:
//    (row 7,0x18), (row 10,0x24), (row 17,0x42), (row 24,0x81).
//  - Control frame with words 0x0A05,0x0C01,0x0F00,0x0A0F, last word to device 0 ->
//    no o_wr_en; o_shutdown=0, o_test=0, o_brightness=0x5 (slot 3 overrides slot 0).
//  - Error frames: CS high after 63 bits -> one o_frame_err pulse, no o_wr_en.
//    65-bit frame -> same response. Next valid frame is decoded normally.
//  - Overlap/reset: second frame shifted in during decode of the first -> all writes of
//    both frames appear in order. rst_n low during DECODE -> o_wr_en=0 at once, no further
//    writes after release.
//  - Loopback: silife_max7219 (i_enable=1, cells from grid rows 0..31) -> this block ->
//    second grid_8x32 -> every row matches after one refresh; o_frame_err never pulses.

Source files
------------

// File: rtl/silife_max7219_rx_pkg.sv
// Register map shared with the silife_max7219 transmitter, plus the receiver's decode state type.
package silife_max7219_rx_pkg;

  localparam logic [3:0] SILIFE_MAX_REG_NOOP      = 4'h0;
  localparam logic [3:0] SILIFE_MAX_REG_DIGIT0    = 4'h1;
  localparam logic [3:0] SILIFE_MAX_REG_DIGIT1    = 4'h2;
  localparam logic [3:0] SILIFE_MAX_REG_DIGIT2    = 4'h3;
  localparam logic [3:0] SILIFE_MAX_REG_DIGIT3    = 4'h4;
  localparam logic [3:0] SILIFE_MAX_REG_DIGIT4    = 4'h5;
  localparam logic [3:0] SILIFE_MAX_REG_DIGIT5    = 4'h6;
  localparam logic [3:0] SILIFE_MAX_REG_DIGIT6    = 4'h7;
  localparam logic [3:0] SILIFE_MAX_REG_DIGIT7    = 4'h8;
  localparam logic [3:0] SILIFE_MAX_REG_DECODE    = 4'h9;
  localparam logic [3:0] SILIFE_MAX_REG_INTENSITY = 4'hA;
  localparam logic [3:0] SILIFE_MAX_REG_SCANLIMIT = 4'hB;
  localparam logic [3:0] SILIFE_MAX_REG_SHUTDOWN  = 4'hC;
  localparam logic [3:0] SILIFE_MAX_REG_TEST      = 4'hF;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_DECODE
  } rx_state_t;

endpackage

// File: rtl/silife_max7219_rx_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin, with single-cycle rise/fall pulses.
module silife_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [1:0] sync_q;
  logic       prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {2{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[0], din};
      prev_q <= sync_q[1];
    end
  end

  always_comb begin
    q    = sync_q[1];
    rise = sync_q[1] & ~prev_q;
    fall = ~sync_q[1] & prev_q;
  end

endmodule

// File: rtl/silife_max7219_rx.sv
// MAX7219-compatible cascaded serial receiver: shifts frames in, latches them on CS rise,
// then decodes one device slot per cycle into grid row writes and shadow control registers.
module silife_max7219_rx
  import silife_max7219_rx_pkg::*;
#(
  parameter int NUM_DEVICES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_cs,
  input  logic       i_sck,
  input  logic       i_mosi,
  output logic       o_wr_en,
  output logic [4:0] o_row_select,
  output logic [7:0] o_cells,
  output logic [3:0] o_brightness,
  output logic       o_shutdown,
  output logic       o_test,
  output logic       o_busy,
  output logic       o_frame_err
);

  localparam int FRAME_BITS = 16 * NUM_DEVICES;
  localparam int CNT_W      = $clog2(FRAME_BITS + 2);
  localparam int SLOT_W     = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1;
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0]  CNT_SAT   = CNT_W'(FRAME_BITS + 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_DEVICES - 1);

  logic cs_q, cs_rise, cs_fall;
  logic sck_q, sck_rise, sck_fall_unused;
  logic [1:0] mosi_sync;

  silife_sync_edge #(.RESET_VAL(1'b1)) u_cs_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (i_cs),
    .q    (cs_q),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  silife_sync_edge #(.RESET_VAL(1'b0)) u_sck_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (i_sck),
    .q    (sck_q),
    .rise (sck_rise),
    .fall (sck_fall_unused)
  );

  // MOSI shares the two-stage delay of SCK so data and edge stay aligned
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mosi_sync <= '0;
    else        mosi_sync <= {mosi_sync[0], i_mosi};
  end

  logic [FRAME_BITS-1:0] shift_q, frame_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  frame_ok;

  assign frame_ok = cs_rise && (cnt_q == CNT_FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q     <= '0;
      cnt_q       <= '0;
      frame_q     <= '0;
      o_frame_err <= 1'b0;
    end else begin
      if (cs_fall) begin
        cnt_q <= '0;
      end else if (!cs_q && sck_rise) begin
        shift_q <= {shift_q[FRAME_BITS-2:0], mosi_sync[1]};
        if (cnt_q != CNT_SAT) cnt_q <= cnt_q + 1'b1;
      end
      if (frame_ok) frame_q <= shift_q;
      o_frame_err <= cs_rise && !frame_ok;
    end
  end

  rx_state_t         state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
    end
  end

  // A freshly latched frame takes priority and restarts decode at slot 0
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    if (frame_ok) begin
      state_d = ST_DECODE;
      slot_d  = '0;
    end else if (state_q == ST_DECODE) begin
      if (slot_q == LAST_SLOT) state_d = ST_IDLE;
      else                     slot_d  = slot_q + 1'b1;
    end
  end

  logic [3:0] addr;
  logic [7:0] data;
  logic       wr_d, shut_d, test_d;
  logic [4:0] row_d;
  logic [7:0] cells_d;
  logic [3:0] bright_d;

  always_comb begin
    addr     = frame_q[{slot_q, 4'd8} +: 4];
    data     = frame_q[{slot_q, 4'd0} +: 8];
    wr_d     = 1'b0;
    row_d    = o_row_select;
    cells_d  = o_cells;
    bright_d = o_brightness;
    shut_d   = o_shutdown;
    test_d   = o_test;
    o_busy   = (state_q == ST_DECODE);
    if (state_q == ST_DECODE) begin
      case (addr)
        SILIFE_MAX_REG_DIGIT0, SILIFE_MAX_REG_DIGIT1, SILIFE_MAX_REG_DIGIT2,
        SILIFE_MAX_REG_DIGIT3, SILIFE_MAX_REG_DIGIT4, SILIFE_MAX_REG_DIGIT5,
        SILIFE_MAX_REG_DIGIT6, SILIFE_MAX_REG_DIGIT7: begin
          wr_d    = 1'b1;
          row_d   = 5'({slot_q, 3'b000}) + 5'(addr) - 5'd1;
          cells_d = data;
        end
        SILIFE_MAX_REG_INTENSITY: bright_d = data[3:0];
        SILIFE_MAX_REG_SHUTDOWN:  shut_d   = ~data[0];
        SILIFE_MAX_REG_TEST:      test_d   = data[0];
        SILIFE_MAX_REG_NOOP, SILIFE_MAX_REG_DECODE, SILIFE_MAX_REG_SCANLIMIT: ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_wr_en      <= 1'b0;
      o_row_select <= '0;
      o_cells      <= '0;
      o_brightness <= '0;
      o_shutdown   <= 1'b1;
      o_test       <= 1'b0;
    end else begin
      o_wr_en      <= wr_d;
      o_row_select <= row_d;
      o_cells      <= cells_d;
      o_brightness <= bright_d;
      o_shutdown   <= shut_d;
      o_test       <= test_d;
    end
  end

endmodule

// File: tb/tb_silife_max7219_rx.sv
// Directed bench for silife_max7219_rx: bit-banged frames with hand-computed row writes.
module tb_silife_max7219_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_cs = 1'b1, i_sck = 1'b0, i_mosi = 1'b0;
  logic       o_wr_en, o_shutdown, o_test, o_busy, o_frame_err;
  logic [4:0] o_row_select;
  logic [7:0] o_cells;
  logic [3:0] o_brightness;

  silife_max7219_rx #(.NUM_DEVICES(4)) dut (
    .clk(clk), .rst_n(rst_n), .i_cs(i_cs), .i_sck(i_sck), .i_mosi(i_mosi),
    .o_wr_en(o_wr_en), .o_row_select(o_row_select), .o_cells(o_cells),
    .o_brightness(o_brightness), .o_shutdown(o_shutdown), .o_test(o_test),
    .o_busy(o_busy), .o_frame_err(o_frame_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cycle = 0;
  int err_pulses = 0;
  logic [12:0] wr_q[$];
  int          wr_cyc[$];

  always @(negedge clk) begin
    cycle <= cycle + 1;
    if (rst_n) begin
      if (o_wr_en) begin
        wr_q.push_back({o_row_select, o_cells});
        wr_cyc.push_back(cycle);
      end
      if (o_frame_err) err_pulses <= err_pulses + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [127:0] v, input int n);
    i_cs = 1'b0;
    idle(4);
    for (int i = n - 1; i >= 0; i--) begin
      i_mosi = v[i];
      i_sck  = 1'b0;
      idle(4);
      i_sck  = 1'b1;
      idle(4);
    end
    i_sck = 1'b0;
    idle(4);
    i_cs = 1'b1;
  endtask

  task automatic check_wr(input string tag, input int idx, input logic [4:0] row, input logic [7:0] cells);
    logic [12:0] got;
    got = (idx < wr_q.size()) ? wr_q[idx] : '1;
    check($sformatf("%s_%0d", tag, idx), {19'd0, got}, {19'd0, row, cells});
  endtask

  task automatic clear_log();
    wr_q.delete();
    wr_cyc.delete();
  endtask

  initial begin
    logic got_busy;
    idle(3);
    check("rst_shutdown", o_shutdown, 1);
    check("rst_bright", o_brightness, 0);
    check("rst_test", o_test, 0);
    check("rst_busy", o_busy, 0);
    check("rst_wr_en", o_wr_en, 0);
    rst_n = 1'b1;
    idle(10);
    check("idle_shutdown", o_shutdown, 1);
    check("idle_frame_err", err_pulses, 0);
    check("idle_writes", wr_q.size(), 0);

    // full data frame
    clear_log();
    send_bits({64'd0, 16'h0181, 16'h0242, 16'h0324, 16'h0818}, 64);
    idle(12);
    check("f1_count", wr_q.size(), 4);
    check_wr("f1", 0, 5'd7,  8'h18);
    check_wr("f1", 1, 5'd10, 8'h24);
    check_wr("f1", 2, 5'd17, 8'h42);
    check_wr("f1", 3, 5'd24, 8'h81);
    if (wr_cyc.size() == 4) check("f1_consecutive", wr_cyc[3] - wr_cyc[0], 3);
    check("f1_busy_done", o_busy, 0);

    // control frames
    clear_log();
    send_bits({64'd0, 16'h0F01, 16'h0000, 16'h0000, 16'h0000}, 64);
    idle(12);
    check("test_set", o_test, 1);
    check("shutdown_kept", o_shutdown, 1);
    send_bits({64'd0, 16'h0A05, 16'h0C01, 16'h0F00, 16'h0A0F}, 64);
    idle(12);
    check("ctl_bright", o_brightness, 4'h5);
    check("ctl_shutdown", o_shutdown, 0);
    check("ctl_test", o_test, 0);
    check("ctl_no_writes", wr_q.size(), 0);

    // error frames
    err_pulses = 0;
    send_bits({64'd0, 16'h0181, 16'h0242, 16'h0324, 16'h0818}, 63);
    idle(12);
    check("short_err", err_pulses, 1);
    send_bits({63'd0, 1'b1, 16'h0181, 16'h0242, 16'h0324, 16'h0818}, 65);
    idle(12);
    check("long_err", err_pulses, 2);
    i_cs = 1'b0;
    idle(6);
    i_cs = 1'b1;
    idle(12);
    check("empty_err", err_pulses, 3);
    check("err_no_writes", wr_q.size(), 0);
    check("err_bright_kept", o_brightness, 4'h5);
    send_bits({64'd0, 16'h0111, 16'h0222, 16'h0333, 16'h0444}, 64);
    idle(12);
    check("after_err_count", wr_q.size(), 4);
    check_wr("after_err", 0, 5'd3,  8'h44);
    check_wr("after_err", 1, 5'd10, 8'h33);
    check_wr("after_err", 2, 5'd17, 8'h22);
    check_wr("after_err", 3, 5'd24, 8'h11);
    check("after_err_pulses", err_pulses, 3);

    // second frame shifted while first decodes
    clear_log();
    send_bits({64'd0, 16'h0181, 16'h0242, 16'h0324, 16'h0818}, 64);
    idle(4);
    send_bits({64'd0, 16'h0585, 16'h0686, 16'h0787, 16'h0188}, 64);
    idle(12);
    check("ovl_count", wr_q.size(), 8);
    check_wr("ovl", 0, 5'd7,  8'h18);
    check_wr("ovl", 1, 5'd10, 8'h24);
    check_wr("ovl", 2, 5'd17, 8'h42);
    check_wr("ovl", 3, 5'd24, 8'h81);
    check_wr("ovl", 4, 5'd0,  8'h88);
    check_wr("ovl", 5, 5'd14, 8'h87);
    check_wr("ovl", 6, 5'd21, 8'h86);
    check_wr("ovl", 7, 5'd28, 8'h85);

    // reset in the middle of decode
    send_bits({64'd0, 16'h0181, 16'h0242, 16'h0324, 16'h0818}, 64);
    got_busy = 1'b0;
    for (int i = 0; i < 20 && !got_busy; i++) begin
      @(posedge clk);
      #1;
      got_busy = o_busy;
    end
    check("rstdec_busy_seen", got_busy, 1);
    rst_n = 1'b0;
    #1;
    check("rstdec_wr_en", o_wr_en, 0);
    check("rstdec_busy", o_busy, 0);
    clear_log();
    idle(3);
    rst_n = 1'b1;
    idle(20);
    check("rstdec_no_writes", wr_q.size(), 0);
    check("rstdec_shutdown", o_shutdown, 1);
    check("rstdec_bright", o_brightness, 0);
    check("rstdec_err", err_pulses, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: got running expected finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
